// File: rtl/count_slot_sched.sv
// Round-robin scheduler sharing one modulo up-counter among NREQ requesters.
// The granted owner gets a slot of len+1 cycles followed by a one-cycle done pulse.
module count_slot_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic [NREQ-1:0]    done
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [PW-1:0] pick;
  logic [PW-1:0] cand;
  logic          pick_vld;
  logic [PW-1:0] owner_nxt;

  // First set request at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign owner_nxt = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StRun;
          owner_d = pick;
          len_d   = len[pick*CW +: CW];
          cnt_d   = '0;
        end
      end
      StRun: begin
        // Cancel wins over terminal count.
        if (!req[owner_q]) begin
          state_d = StIdle;
          ptr_d   = owner_nxt;
        end else if (cnt_q == len_q) begin
          state_d = StDone;
          ptr_d   = owner_nxt;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode registered state only; no input-to-output paths.
  always_comb begin
    gnt   = '0;
    done  = '0;
    busy  = (state_q == StRun);
    count = '1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt[i]  = (state_q == StRun)  && (owner_q == PW'(i));
      done[i] = (state_q == StDone) && (owner_q == PW'(i));
    end
    if (state_q == StRun) begin
      count = cnt_q;
    end
  end

endmodule

// File: tb/tb_count_slot_sched.sv
// Directed bench for count_slot_sched: one task per scenario, expectations hand-derived.
module tb_count_slot_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] len = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  count;
  logic [3:0]  done;

  int checks = 0;
  int failures = 0;

  count_slot_sched #(.NREQ(4), .CW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    len = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, done, count} !== {4'b0000, 1'b0, 4'b0000, 4'hf}) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b busy=%b done=%b count=%0d exp 0000/0/0000/15",
               gnt, busy, done, count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0001;
    len = {4'd0, 4'd0, 4'd0, 4'd8};
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || count !== 4'(k) || done !== 4'b0000) begin
        failures++;
        $display("FAIL basic_run k=%0d got gnt=%b busy=%b count=%0d done=%b exp 0001/1/%0d/0000",
                 k, gnt, busy, count, done, k);
      end
      // len change after grant must not shorten the slot
      if (k == 0) len = {4'd0, 4'd0, 4'd0, 4'd2};
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || gnt !== 4'b0000 || busy !== 1'b0 || count !== 4'hf) begin
      failures++;
      $display("FAIL basic_done got done=%b gnt=%b busy=%b count=%0d exp 0001/0000/0/15",
               done, gnt, busy, count);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (done !== 4'b0000 || gnt !== 4'b0000 || count !== 4'hf) begin
      failures++;
      $display("FAIL basic_idle got done=%b gnt=%b count=%0d exp 0000/0000/15", done, gnt, count);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [3:0] exp_done;
    logic [3:0] exp_cnt;
    int owner;
    int phase;
    do_reset();
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      owner    = (c / 4) % 4;
      phase    = c % 4;
      exp_gnt  = (phase < 2) ? 4'(1 << owner) : 4'b0000;
      exp_done = (phase == 2) ? 4'(1 << owner) : 4'b0000;
      exp_cnt  = (phase < 2) ? 4'(phase) : 4'hf;
      checks++;
      if (gnt !== exp_gnt || done !== exp_done || count !== exp_cnt) begin
        failures++;
        $display("FAIL rr c=%0d got gnt=%b done=%b count=%0d exp %b/%b/%0d",
                 c, gnt, done, count, exp_gnt, exp_done, exp_cnt);
      end
      if (phase == 2) req[owner] = 1'b0;
      if (phase == 3) req[owner] = 1'b1;
    end
    req = '0;
  endtask

  task automatic test_len_zero();
    do_reset();
    req = 4'b0001;
    len = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL len0_run got gnt=%b busy=%b count=%0d exp 0001/1/0", gnt, busy, count);
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0001 || busy !== 1'b0 || count !== 4'hf) begin
      failures++;
      $display("FAIL len0_done got done=%b busy=%b count=%0d exp 0001/0/15", done, busy, count);
    end
    req = '0;
  endtask

  task automatic test_len_max();
    do_reset();
    req = 4'b0100;
    len = {4'd0, 4'd15, 4'd0, 4'd0};
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0100 || busy !== 1'b1 || count !== 4'(k)) begin
        failures++;
        $display("FAIL len15_run k=%0d got gnt=%b busy=%b count=%0d exp 0100/1/%0d",
                 k, gnt, busy, count, k);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 4'b0100 || busy !== 1'b0 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL len15_done got done=%b busy=%b gnt=%b exp 0100/0/0000", done, busy, gnt);
    end
    req = '0;
  endtask

  task automatic test_cancel();
    do_reset();
    req = 4'b0011;
    len = {4'd0, 4'd0, 4'd2, 4'd8};
    repeat (4) @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || count !== 4'd3) begin
      failures++;
      $display("FAIL cancel_pre got gnt=%b count=%0d exp 0001/3", gnt, count);
    end
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || count !== 4'hf) begin
      failures++;
      $display("FAIL cancel_idle got gnt=%b busy=%b done=%b count=%0d exp 0000/0/0000/15",
               gnt, busy, done, count);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || count !== 4'd0) begin
      failures++;
      $display("FAIL cancel_regrant got gnt=%b count=%0d exp 0010/0", gnt, count);
    end
    repeat (2) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 4'b0010) begin
      failures++;
      $display("FAIL cancel_done1 got done=%b exp 0010", done);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    // Complete a slot for requester 0 so the pointer moves to 1.
    req = 4'b0001;
    len = '0;
    repeat (2) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0101;
    len = {4'd0, 4'd9, 4'd0, 4'd0};
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL arst_pregrant got gnt=%b exp 0100", gnt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_count5 got count=%0d busy=%b exp 5/1", count, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000 || count !== 4'hf) begin
      failures++;
      $display("FAIL arst_immediate got gnt=%b busy=%b done=%b count=%0d exp 0000/0/0000/15",
               gnt, busy, done, count);
    end
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL arst_ptr0 got gnt=%b exp 0001", gnt);
    end
    req = '0;
  endtask

  task automatic test_held_regrant();
    do_reset();
    req = 4'b0001;
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 4'b0001 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL held_done got done=%b gnt=%b exp 0001/0000", done, gnt);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
      failures++;
      $display("FAIL held_idle got gnt=%b busy=%b done=%b exp 0000/0/0000", gnt, busy, done);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || count !== 4'd0) begin
      failures++;
      $display("FAIL held_regrant got gnt=%b count=%0d exp 0001/0", gnt, count);
    end
    req = 4'b0011;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 4'b0001) begin
      failures++;
      $display("FAIL held_done2 got done=%b exp 0001", done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL held_rr_ahead got gnt=%b exp 0010", gnt);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_len_zero();
    test_len_max();
    test_cancel();
    test_async_reset();
    test_held_regrant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
